isp_awb: RTL and testbench
==========================

ISP_AWB -- requirements
Module: isp_awb

Gray-world auto white balance. Sits directly downstream of the RAW-to-RGB888 demosaic stage and upstream of the RGB-to-YCbCr CSC stage. It collects per-channel sums over one frame, computes the R and B gains during vertical blanking, and applies them to the next frame.

Interface
- REQ-001 BITS, 8: pixel component width.
- REQ-002 WIDTH, 1920: active pixels per line; informational only, no logic depends on it.
- REQ-003 HEIGHT, 1080: active lines per frame; informational only.
- REQ-004 GAIN_W, 12: gain width, unsigned Q4.8; 256 = unity.
- REQ-005 pclk  input  1  pixel clock; all logic on its rising edge.
- REQ-006 rst_n  input  1  reset, asynchronous, active-low.
- REQ-007 awb_en  input  1  1 = apply computed gains; 0 = bypass with unity gains.
- REQ-008 in_vsync  input  1  frame valid, active-high for the whole frame.
- REQ-009 in_href  input  1  line valid; a pixel is valid when in_vsync & in_href.
- REQ-010 in_r / in_g / in_b  input  BITS each  RGB pixel.
- REQ-011 out_vsync / out_href  output  1 each  in_vsync / in_href delayed 2 cycles.
- REQ-012 out_r / out_g / out_b  output  BITS each  white-balanced pixel.
- REQ-013 gain_r / gain_b  output  GAIN_W each  currently applied gains.

Function
- REQ-014 Statistics:
  - Three 32-bit accumulators sum in_r, in_g, in_b on every valid pixel.
  - Accumulators clear on the rising edge of in_vsync.
  - Accumulators never wrap; the design relies on at most 2^24 pixels per frame.
- REQ-015 Frame end (falling edge of in_vsync):
  - Snapshot R_sum, G_sum, B_sum into holding registers.
  - Start the gain FSM.
- REQ-016 FSM states: IDLE -> CHK_R -> DIV_R -> CHK_B -> DIV_B -> DONE.
  - DONE holds until the next commit or frame end.
- REQ-017 CHK_x (x = R or B):
  - If x_sum == 0: gain_x_new = 256, skip DIV_x.
  - Else if G_sum >= (x_sum << 4): gain_x_new = 4095, skip DIV_x.
  - Otherwise enter DIV_x.
- REQ-018 DIV_x computes floor((G_sum << 8) / x_sum) with a restoring divider:
  - one quotient bit per cycle, exactly 12 cycles;
  - the result is truncated, not rounded.
- REQ-019 Worst-case FSM run: 1 + 12 + 1 + 12 + 1 = 27 cycles from frame end to DONE.
- REQ-020 A frame end while the FSM is not in IDLE/DONE re-snapshots the sums and restarts at CHK_R.
- REQ-021 Commit, on the rising edge of in_vsync:
  - If the FSM is in DONE: gain_r/gain_b take the new values and the FSM returns to IDLE.
  - Otherwise the previous gains are kept.
  - Gains never change while in_vsync is high.
- REQ-022 Bypass: when awb_en = 0, the datapath uses 256 for both gains, but gain_r/gain_b outputs still show the committed values.
  - Statistics and the FSM keep running.
  - awb_en is sampled combinationally at pipeline stage 1.
- REQ-023 Datapath stage 1 registers the products:
  - p_r = in_r * eff_gain_r (20 bits);
  - p_b = in_b * eff_gain_b (20 bits);
  - in_g is delayed unchanged.
- REQ-024 Datapath stage 2:
  - out_x = min(255, (p_x + 128) >> 8);
  - out_g = in_g delayed 2 cycles.
- REQ-025 Latency: data, href and vsync are all exactly 2 cycles, with no throughput stall; one pixel per clock is accepted continuously.
- REQ-026 Pixels outside the valid window pass through the datapath unchanged in timing; their values are don't-care.

Reset
- REQ-027 While rst_n = 0, immediately:
  - all outputs = 0, except gain_r = gain_b = 256;
  - accumulators and snapshots = 0;
  - FSM = IDLE;
  - pipeline flushed.
- REQ-028 Reset deasserted mid-frame: accumulation starts only after the next rising edge of in_vsync; the partial frame is ignored.

Verification
(Bench uses WIDTH = 8, HEIGHT = 4, giving 32 pixels per frame.)
- REQ-029 Frame 1 uniform R=64, G=128, B=32 -> after frame end FSM reaches DONE in ≤27 cycles; at frame 2 start gain_r = 512, gain_b = 1024; frame 2 same input -> out = (128, 128, 128) with 2-cycle lag.
- REQ-030 Saturation: frame R=4, G=255, B=0 -> gain_r = 4095 and gain_b = 256 at next frame start; next frame input R=4 -> out_r = 64.
- REQ-031 Clamp: gain_b = 1024, in_b = 100 -> out_b = 255; in_b = 60 -> out_b = 240.
- REQ-032 Bypass: awb_en = 0 with gain_r = 512 committed, in = (50, 70, 90) -> out = (50, 70, 90), gain_r still reads 512.
- REQ-033 Short blanking: next frame starts 10 cycles after frame end -> gains unchanged for that frame; computation completes and commits at the following frame start.
- REQ-034 Reset mid-frame: assert rst_n = 0 during a valid pixel -> outputs 0 and gains 256 with no clock edge; after release the first full frame produces correct gains per REQ-029.

Source files
------------

// File: rtl/isp_awb.sv
// isp_awb: gray-world auto white balance between demosaic and CSC.
//   Collects R/G/B sums over each frame, derives R and B gains (unsigned
//   Q4.8, 256 = unity) during vertical blanking with a bit-serial divider,
//   and applies them from the next frame start. Datapath latency is 2 cycles.
// Ports:
//   pclk, rst_n            pixel clock, asynchronous active-low reset
//   awb_en                 1 = apply committed gains, 0 = unity gains
//   in_vsync/in_href       frame / line valid; pixel valid = in_vsync & in_href
//   in_r/in_g/in_b         RGB pixel
//   out_vsync/out_href     sync delayed by 2 cycles
//   out_r/out_g/out_b      white-balanced pixel
//   gain_r/gain_b          currently committed gains
module isp_awb #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int GAIN_W = 12
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              awb_en,
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic [BITS-1:0]   in_r,
  input  logic [BITS-1:0]   in_g,
  input  logic [BITS-1:0]   in_b,
  output logic              out_vsync,
  output logic              out_href,
  output logic [BITS-1:0]   out_r,
  output logic [BITS-1:0]   out_g,
  output logic [BITS-1:0]   out_b,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_b
);

  localparam int PROD_W = BITS + GAIN_W;
  localparam int RND_W  = PROD_W - 8;
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(256);
  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHK_R = 3'd1;
  localparam logic [2:0] S_DIV_R = 3'd2;
  localparam logic [2:0] S_CHK_B = 3'd3;
  localparam logic [2:0] S_DIV_B = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // The 32-bit sums cannot wrap for frames of up to 2^24 pixels; larger
  // frame geometries are outside what this block supports.
  if (WIDTH * HEIGHT > 16777216) begin : g_frame_too_large
  end

  function automatic logic [BITS-1:0] round_sat(input logic [PROD_W-1:0] p);
    logic [RND_W-1:0] q;
    q = RND_W'((p + PROD_W'(128)) >> 8);
    if (q > RND_W'((1 << BITS) - 1)) return '1;
    return q[BITS-1:0];
  endfunction

  // Frame boundary detection. synced stays low until in_vsync has been seen
  // low after reset, so a frame already in progress at reset release is ignored.
  logic vsync_d, synced;
  logic frame_start, frame_end, pix_vld;

  assign frame_start = synced & in_vsync & ~vsync_d;
  assign frame_end   = synced & ~in_vsync & vsync_d;
  assign pix_vld     = synced & in_vsync & in_href;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      synced  <= 1'b0;
    end else begin
      vsync_d <= in_vsync;
      if (!in_vsync) synced <= 1'b1;
    end
  end

  // Per-frame statistics
  logic [31:0] sum_r, sum_g, sum_b;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      sum_g <= '0;
      sum_b <= '0;
    end else if (frame_start) begin
      sum_r <= pix_vld ? 32'(in_r) : '0;
      sum_g <= pix_vld ? 32'(in_g) : '0;
      sum_b <= pix_vld ? 32'(in_b) : '0;
    end else if (pix_vld) begin
      sum_r <= sum_r + 32'(in_r);
      sum_g <= sum_g + 32'(in_g);
      sum_b <= sum_b + 32'(in_b);
    end
  end

  // Gain FSM with restoring divider: q = floor((G << 8) / x), 12 bits.
  // CHK guarantees G < 16*x, so (G << 8) >> 12 < x and the remainder can be
  // seeded with G >> 4 while the low 12 dividend bits shift in one per cycle.
  logic [2:0]        state;
  logic [31:0]       hold_r, hold_g, hold_b;
  logic [31:0]       rem;
  logic [11:0]       div_low;
  logic [11:0]       quo;
  logic [3:0]        cnt;
  logic [GAIN_W-1:0] new_r, new_b;

  logic [31:0] chk_x;
  logic        chk_sat;
  logic [32:0] divisor, rem_sh;
  logic        q_bit;
  logic [31:0] rem_nxt;

  assign chk_x   = (state == S_CHK_B) ? hold_b : hold_r;
  assign chk_sat = {4'b0, hold_g} >= {chk_x, 4'b0};
  assign divisor = {1'b0, (state == S_DIV_B) ? hold_b : hold_r};
  assign rem_sh  = {rem, div_low[11]};
  assign q_bit   = rem_sh >= divisor;
  assign rem_nxt = q_bit ? 32'(rem_sh - divisor) : rem_sh[31:0];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hold_r  <= '0;
      hold_g  <= '0;
      hold_b  <= '0;
      rem     <= '0;
      div_low <= '0;
      quo     <= '0;
      cnt     <= '0;
      new_r   <= UNITY;
      new_b   <= UNITY;
      gain_r  <= UNITY;
      gain_b  <= UNITY;
    end else if (frame_end) begin
      hold_r <= sum_r;
      hold_g <= sum_g;
      hold_b <= sum_b;
      state  <= S_CHK_R;
    end else if (frame_start && state == S_DONE) begin
      gain_r <= new_r;
      gain_b <= new_b;
      state  <= S_IDLE;
    end else begin
      case (state)
        S_CHK_R, S_CHK_B: begin
          if (chk_x == '0 || chk_sat) begin
            if (state == S_CHK_R) begin
              new_r <= (chk_x == '0) ? UNITY : GAIN_MAX;
              state <= S_CHK_B;
            end else begin
              new_b <= (chk_x == '0) ? UNITY : GAIN_MAX;
              state <= S_DONE;
            end
          end else begin
            rem     <= {4'b0, hold_g[31:4]};
            div_low <= {hold_g[3:0], 8'b0};
            quo     <= '0;
            cnt     <= '0;
            state   <= (state == S_CHK_R) ? S_DIV_R : S_DIV_B;
          end
        end
        S_DIV_R, S_DIV_B: begin
          rem     <= rem_nxt;
          div_low <= {div_low[10:0], 1'b0};
          quo     <= {quo[10:0], q_bit};
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd11) begin
            if (state == S_DIV_R) begin
              new_r <= GAIN_W'({quo[10:0], q_bit});
              state <= S_CHK_B;
            end else begin
              new_b <= GAIN_W'({quo[10:0], q_bit});
              state <= S_DONE;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  // Stage 1: gain multiply
  logic [GAIN_W-1:0] eff_gain_r, eff_gain_b;
  logic [PROD_W-1:0] prod_r_p1, prod_b_p1;
  logic [BITS-1:0]   g_p1;
  logic              vsync_p1, href_p1;

  assign eff_gain_r = awb_en ? gain_r : UNITY;
  assign eff_gain_b = awb_en ? gain_b : UNITY;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_p1 <= '0;
      prod_b_p1 <= '0;
      g_p1      <= '0;
      vsync_p1  <= 1'b0;
      href_p1   <= 1'b0;
    end else begin
      prod_r_p1 <= PROD_W'(in_r) * PROD_W'(eff_gain_r);
      prod_b_p1 <= PROD_W'(in_b) * PROD_W'(eff_gain_b);
      g_p1      <= in_g;
      vsync_p1  <= in_vsync;
      href_p1   <= in_href;
    end
  end

  // Stage 2: round, saturate, output register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_vsync <= 1'b0;
      out_href  <= 1'b0;
    end else begin
      out_r     <= round_sat(prod_r_p1);
      out_g     <= g_p1;
      out_b     <= round_sat(prod_b_p1);
      out_vsync <= vsync_p1;
      out_href  <= href_p1;
    end
  end

endmodule

// File: tb/tb_isp_awb.sv
// tb_isp_awb: self-checking bench for isp_awb with an 8x4 frame.
//   Expected pixels are pushed to a queue as they are driven and compared
//   when the DUT presents them; gains are predicted by a gray-world model.
module tb_isp_awb;
  localparam int BITS   = 8;
  localparam int GAIN_W = 12;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;

  logic              pclk = 1'b0;
  logic              rst_n = 1'b1;
  logic              awb_en = 1'b1;
  logic              in_vsync = 1'b0;
  logic              in_href = 1'b0;
  logic [BITS-1:0]   in_r = '0, in_g = '0, in_b = '0;
  logic              out_vsync, out_href;
  logic [BITS-1:0]   out_r, out_g, out_b;
  logic [GAIN_W-1:0] gain_r, gain_b;

  isp_awb #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .GAIN_W(GAIN_W)) dut (
    .pclk(pclk), .rst_n(rst_n), .awb_en(awb_en),
    .in_vsync(in_vsync), .in_href(in_href),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_vsync(out_vsync), .out_href(out_href),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .gain_r(gain_r), .gain_b(gain_b)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cur_gr = 256, cur_gb = 256;
  int   pend_gr = 256, pend_gb = 256;
  bit   pend_ok = 1'b0;
  int   pr[3], pg[3], pb[3];
  logic [7:0] last_r = '0, last_g = '0, last_b = '0, max_b = '0;
  logic [1:0] hist0 = '0, hist1 = '0;

  function automatic int exp_gain(longint g_sum, longint x_sum);
    longint q;
    if (x_sum == 0) return 256;
    q = (g_sum * 256) / x_sum;
    return (q > 4095) ? 4095 : int'(q);
  endfunction

  function automatic logic [7:0] exp_pix(int v, int g);
    int t;
    t = (v * g + 128) / 256;
    return (t > 255) ? 8'd255 : 8'(t);
  endfunction

  // Monitor: sync latency and scoreboard compare, sampled on the falling edge.
  initial begin
    pix_t e;
    forever begin
      @(negedge pclk);
      if (!rst_n) begin
        hist1 = 2'b00;
        hist0 = {in_vsync, in_href};
      end else begin
        n_checks++;
        if ({out_vsync, out_href} !== hist1)
          $display("FAIL sync_latency: out vsync/href=%b required %b at %0t",
                   {out_vsync, out_href}, hist1, $time);
        else n_pass++;
        if (out_vsync && out_href) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_extra: got (%0d,%0d,%0d) but no pixel expected at %0t",
                     out_r, out_g, out_b, $time);
          end else begin
            e = exp_q.pop_front();
            if ({out_r, out_g, out_b} !== e)
              $display("FAIL pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d) at %0t",
                       out_r, out_g, out_b, e.r, e.g, e.b, $time);
            else n_pass++;
          end
          last_r = out_r;
          last_g = out_g;
          last_b = out_b;
          if (out_b > max_b) max_b = out_b;
        end
        hist1 = hist0;
        hist0 = {in_vsync, in_href};
      end
    end
  end

  task automatic drive_cycle(input logic vs, input logic hs, input int r, input int g, input int b);
    pix_t e;
    @(posedge pclk);
    #1;
    in_vsync = vs;
    in_href  = hs;
    in_r     = 8'(r);
    in_g     = 8'(g);
    in_b     = 8'(b);
    if (vs && hs && rst_n) begin
      e.r = exp_pix(r, awb_en ? cur_gr : 256);
      e.g = 8'(g);
      e.b = exp_pix(b, awb_en ? cur_gb : 256);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_uniform(input int r, input int g, input int b);
    for (int i = 0; i < 3; i++) begin
      pr[i] = r;
      pg[i] = g;
      pb[i] = b;
    end
  endtask

  // One frame: rise, 2 lead cycles, HEIGHT lines of WIDTH pixels with a
  // 2-cycle line gap, then 'blank' cycles of vertical blanking.
  task automatic send_frame(input int blank);
    longint sr = 0, sg = 0, sb = 0;
    int k = 0;
    if (pend_ok) begin
      cur_gr  = pend_gr;
      cur_gb  = pend_gb;
      pend_ok = 1'b0;
    end
    repeat (2) drive_cycle(1'b1, 1'b0, 0, 0, 0);
    for (int l = 0; l < HEIGHT; l++) begin
      for (int p = 0; p < WIDTH; p++) begin
        drive_cycle(1'b1, 1'b1, pr[k % 3], pg[k % 3], pb[k % 3]);
        sr += pr[k % 3];
        sg += pg[k % 3];
        sb += pb[k % 3];
        k++;
      end
      repeat (2) drive_cycle(1'b1, 1'b0, 0, 0, 0);
    end
    repeat (blank) drive_cycle(1'b0, 1'b0, 0, 0, 0);
    pend_gr = exp_gain(sg, sr);
    pend_gb = exp_gain(sg, sb);
    pend_ok = (blank >= 28);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_vsync, out_href, out_r, out_g, out_b} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {out_vsync, out_href, out_r, out_g, out_b});
    else n_pass++;
    n_checks++;
    if (gain_r !== 12'd256) $display("FAIL reset_gain_r: got %0d required 256", gain_r);
    else n_pass++;
    n_checks++;
    if (gain_b !== 12'd256) $display("FAIL reset_gain_b: got %0d required 256", gain_b);
    else n_pass++;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_awb_gain();
    set_uniform(64, 128, 32);
    send_frame(28);
    send_frame(28);
    n_checks++;
    if (gain_r !== 12'd512) $display("FAIL awb_gain_r: got %0d required 512", gain_r);
    else n_pass++;
    n_checks++;
    if (gain_b !== 12'd1024) $display("FAIL awb_gain_b: got %0d required 1024", gain_b);
    else n_pass++;
    n_checks++;
    if ({last_r, last_g, last_b} !== {8'd128, 8'd128, 8'd128})
      $display("FAIL awb_out: got (%0d,%0d,%0d) required (128,128,128)", last_r, last_g, last_b);
    else n_pass++;
  endtask

  task automatic test_clamp();
    set_uniform(64, 128, 32);
    pb[1] = 60;
    pb[2] = 100;
    max_b = '0;
    send_frame(28);
    n_checks++;
    if (gain_b !== 12'd1024) $display("FAIL clamp_gain_b: got %0d required 1024", gain_b);
    else n_pass++;
    n_checks++;
    if (max_b !== 8'd255) $display("FAIL clamp_sat: max out_b %0d required 255", max_b);
    else n_pass++;
    n_checks++;
    if (last_b !== 8'd240) $display("FAIL clamp_60: got out_b %0d required 240", last_b);
    else n_pass++;
  endtask

  task automatic test_saturation();
    set_uniform(4, 255, 0);
    send_frame(28);
    send_frame(28);
    n_checks++;
    if (gain_r !== 12'd4095) $display("FAIL sat_gain_r: got %0d required 4095", gain_r);
    else n_pass++;
    n_checks++;
    if (gain_b !== 12'd256) $display("FAIL zero_gain_b: got %0d required 256", gain_b);
    else n_pass++;
    n_checks++;
    if (last_r !== 8'd64) $display("FAIL sat_out_r: got %0d required 64", last_r);
    else n_pass++;
  endtask

  task automatic test_bypass();
    set_uniform(64, 128, 32);
    send_frame(28);
    awb_en = 1'b0;
    set_uniform(50, 70, 90);
    send_frame(28);
    n_checks++;
    if (gain_r !== 12'd512) $display("FAIL bypass_gain_r: got %0d required 512", gain_r);
    else n_pass++;
    n_checks++;
    if ({last_r, last_g, last_b} !== {8'd50, 8'd70, 8'd90})
      $display("FAIL bypass_out: got (%0d,%0d,%0d) required (50,70,90)", last_r, last_g, last_b);
    else n_pass++;
    awb_en = 1'b1;
  endtask

  task automatic test_short_blanking();
    set_uniform(64, 128, 32);
    send_frame(10);
    n_checks++;
    if ({gain_r, gain_b} !== {12'd358, 12'd199})
      $display("FAIL gray_gains: got (%0d,%0d) required (358,199)", gain_r, gain_b);
    else n_pass++;
    send_frame(28);
    n_checks++;
    if ({gain_r, gain_b} !== {12'd358, 12'd199})
      $display("FAIL short_blank_hold: got (%0d,%0d) required (358,199)", gain_r, gain_b);
    else n_pass++;
    send_frame(28);
    n_checks++;
    if ({gain_r, gain_b} !== {12'd512, 12'd1024})
      $display("FAIL short_blank_commit: got (%0d,%0d) required (512,1024)", gain_r, gain_b);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    repeat (2) drive_cycle(1'b1, 1'b0, 0, 0, 0);
    repeat (6) drive_cycle(1'b1, 1'b1, 64, 128, 32);
    #1 rst_n = 1'b0;
    exp_q.delete();
    cur_gr  = 256;
    cur_gb  = 256;
    pend_ok = 1'b0;
    #1;
    n_checks++;
    if ({out_vsync, out_href, out_r, out_g, out_b} !== '0)
      $display("FAIL midreset_outputs: got %h required 0", {out_vsync, out_href, out_r, out_g, out_b});
    else n_pass++;
    n_checks++;
    if ({gain_r, gain_b} !== {12'd256, 12'd256})
      $display("FAIL midreset_gains: got (%0d,%0d) required (256,256)", gain_r, gain_b);
    else n_pass++;
    repeat (3) drive_cycle(1'b1, 1'b0, 0, 0, 0);
    @(negedge pclk);
    #1 rst_n = 1'b1;
    repeat (8) drive_cycle(1'b1, 1'b1, 200, 10, 200);
    repeat (2) drive_cycle(1'b1, 1'b0, 0, 0, 0);
    repeat (40) drive_cycle(1'b0, 1'b0, 0, 0, 0);
    set_uniform(64, 128, 32);
    send_frame(28);
    n_checks++;
    if ({gain_r, gain_b} !== {12'd256, 12'd256})
      $display("FAIL partial_ignored: got (%0d,%0d) required (256,256)", gain_r, gain_b);
    else n_pass++;
    send_frame(28);
    n_checks++;
    if ({gain_r, gain_b} !== {12'd512, 12'd1024})
      $display("FAIL post_reset_gains: got (%0d,%0d) required (512,1024)", gain_r, gain_b);
    else n_pass++;
    n_checks++;
    if ({last_r, last_g, last_b} !== {8'd128, 8'd128, 8'd128})
      $display("FAIL post_reset_out: got (%0d,%0d,%0d) required (128,128,128)", last_r, last_g, last_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_awb_gain();
    test_clamp();
    test_saturation();
    test_bypass();
    test_short_blanking();
    test_reset_mid_frame();
    repeat (5) drive_cycle(1'b0, 1'b0, 0, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d pixels left, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
